dwcv_sched: RTL

Sequential scheduler and shared MAC for one depthwise-separable convolution layer. On `start` it runs the depthwise phase (one K×K kernel per input channel, results to an intermediate buffer). It then runs the pointwise phase (1×1 mixing across channels, results to the output buffer). All work goes through one signed multiply-accumulate unit, replacing the fully parallel combinational layer with a memory-backed, time-multiplexed one. It drives external synchronous RAM/ROM ports and holds no image storage itself.

---
 rtl/dwcv_sched_if.sv | 48 ++++
 rtl/dwcv_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwcv_sched_if.sv
// dwcv_sched_if: handshake and memory-port bundle for the depthwise-separable
// convolution scheduler.
//   master : scheduler side (drives strobes, addresses, write data, busy/done)
//   slave  : environment side (drives start and the read data returned by
//            the activation RAMs and weight ROM)
// Address widths are derived from the layer geometry exactly as the scheduler
// derives them, so both ends agree for any parameter set.
interface dwcv_sched_if #(
   parameter int INPUT_SIZE      = 32,
   parameter int INPUT_CHANNELS  = 3,
   parameter int OUTPUT_CHANNELS = 3,
   parameter int KERNEL_SIZE     = 3,
   parameter int PX_SIZE         = 8
);
   localparam int OS   = INPUT_SIZE - KERNEL_SIZE + 1;
   localparam int MAXC = (INPUT_CHANNELS > OUTPUT_CHANNELS) ? INPUT_CHANNELS : OUTPUT_CHANNELS;
   localparam int RAW  = $clog2(INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS);
   localparam int WAW  = $clog2(MAXC * OS * OS);
   localparam int WTW  = $clog2(INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE + INPUT_CHANNELS
                                + OUTPUT_CHANNELS * INPUT_CHANNELS + OUTPUT_CHANNELS);

   logic               start;
   logic               busy;
   logic               done;
   logic               rd_en;
   logic               rd_sel;
   logic [RAW-1:0]     rd_addr;
   logic [PX_SIZE-1:0] rd_data;
   logic               wt_en;
   logic [WTW-1:0]     wt_addr;
   logic [PX_SIZE-1:0] wt_data;
   logic               wr_en;
   logic               wr_sel;
   logic [WAW-1:0]     wr_addr;
   logic [PX_SIZE-1:0] wr_data;

   modport master (
      input  start, rd_data, wt_data,
      output busy, done, rd_en, rd_sel, rd_addr, wt_en, wt_addr,
             wr_en, wr_sel, wr_addr, wr_data
   );

   modport slave (
      output start, rd_data, wt_data,
      input  busy, done, rd_en, rd_sel, rd_addr, wt_en, wt_addr,
             wr_en, wr_sel, wr_addr, wr_data
   );
endinterface

// File: rtl/dwcv_sched.sv
// dwcv_sched: time-multiplexed depthwise-separable convolution layer.
// One signed MAC runs the depthwise phase (K x K per channel into the
// intermediate RAM) and then the pointwise phase (1 x 1 across channels into
// the output RAM). All image/weight storage is external synchronous memory.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : dwcv_sched_if.master (start/busy/done, activation read port,
//               weight ROM read port, result write port)
// Each output pixel takes a slot of N+2 cycles (N = K*K or IC): taps issued in
// cycles 0..N-1, bias read in cycle N, products accumulated in cycles 1..N,
// result registered in cycle N+1 and presented on wr_* the following cycle.
module dwcv_sched #(
   parameter int INPUT_SIZE      = 32,
   parameter int INPUT_CHANNELS  = 3,
   parameter int OUTPUT_CHANNELS = 3,
   parameter int KERNEL_SIZE     = 3,
   parameter int PX_SIZE         = 8,
   parameter int ACC_SIZE        = 24,
   parameter int SHIFT           = 0
) (
   input  logic             clk,
   input  logic             rst,
   dwcv_sched_if.master     bus
);
   localparam int IS    = INPUT_SIZE;
   localparam int IC    = INPUT_CHANNELS;
   localparam int OC    = OUTPUT_CHANNELS;
   localparam int K     = KERNEL_SIZE;
   localparam int P     = PX_SIZE;
   localparam int A     = ACC_SIZE;
   localparam int OS    = IS - K + 1;
   localparam int KK    = K * K;
   localparam int MAXC  = (IC > OC) ? IC : OC;
   localparam int MAXN  = (KK > IC) ? KK : IC;
   localparam int RAW   = $clog2(IS * IS * IC);
   localparam int WAW   = $clog2(MAXC * OS * OS);
   localparam int WTW   = $clog2(IC * KK + IC + OC * IC + OC);
   localparam int CW    = $clog2(MAXC + 1);
   localparam int OW    = $clog2(OS + 1);
   localparam int SW    = $clog2(MAXN + 2);
   localparam int KW    = $clog2(K + 1);
   localparam int WB_DB = IC * KK;
   localparam int WB_PK = WB_DB + IC;
   localparam int WB_PB = WB_PK + OC * IC;
   localparam logic signed [A-1:0] SAT_HI = A'((1 << (P - 1)) - 1);
   localparam logic signed [A-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DW   = 3'd1,
      S_GAP  = 3'd2,
      S_PW   = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   function automatic logic [P-1:0] sat_fn(input logic signed [A-1:0] v);
      logic [P-1:0] r;
      if (v > SAT_HI) begin
         r = SAT_HI[P-1:0];
      end else if (v < SAT_LO) begin
         r = SAT_LO[P-1:0];
      end else begin
         r = v[P-1:0];
      end
      return r;
   endfunction

   state_t                state_q, state_d;
   logic [CW-1:0]         ch_q, ch_d, last_ch_s;
   logic [OW-1:0]         oy_q, oy_d, ox_q, ox_d;
   logic [SW-1:0]         s_q, s_d, n_last_s;
   logic [KW-1:0]         ky_q, ky_d, kx_q, kx_d;
   logic signed [A-1:0]   acc_q, acc_d, sum_s, shifted_s;
   logic signed [2*P-1:0] prod_s;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  rd_en_q, rd_en_d, rd_sel_q, rd_sel_d;
   logic [RAW-1:0]        rd_addr_q, rd_addr_d;
   logic                  wt_en_q, wt_en_d;
   logic [WTW-1:0]        wt_addr_q, wt_addr_d;
   logic                  wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
   logic [WAW-1:0]        wr_addr_q, wr_addr_d;
   logic [P-1:0]          wr_data_q, wr_data_d;

   // Sequencer: phase FSM, loop counters, MAC datapath and write-back values
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      oy_d      = oy_q;
      ox_d      = ox_q;
      s_d       = s_q;
      ky_d      = ky_q;
      kx_d      = kx_q;
      acc_d     = acc_q;
      done_d    = 1'b0;
      wr_en_d   = 1'b0;
      wr_sel_d  = wr_sel_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      n_last_s  = (state_q == S_PW) ? SW'(IC) : SW'(KK);
      last_ch_s = (state_q == S_PW) ? CW'(OC - 1) : CW'(IC - 1);
      prod_s    = $signed({{P{bus.rd_data[P-1]}}, bus.rd_data})
                * $signed({{P{bus.wt_data[P-1]}}, bus.wt_data});
      sum_s     = acc_q + $signed({{(A - P){bus.wt_data[P-1]}}, bus.wt_data});
      shifted_s = sum_s >>> SHIFT;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_DW;
               ch_d    = '0;
               oy_d    = '0;
               ox_d    = '0;
               s_d     = '0;
               ky_d    = '0;
               kx_d    = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DW, S_PW: begin
            // Cycle 0 clears, cycles 1..N add the product of the previous tap,
            // cycle N+1 sees the bias on wt_data and produces the pixel.
            if (s_q == SW'(0)) begin
               acc_d = {A{1'b0}};
            end else if (s_q == n_last_s + SW'(1)) begin
               wr_en_d   = 1'b1;
               wr_sel_d  = (state_q == S_PW);
               wr_addr_d = WAW'((32'(ch_q) * 32'(OS) + 32'(oy_q)) * 32'(OS) + 32'(ox_q));
               wr_data_d = sat_fn(shifted_s);
            end else begin
               acc_d = acc_q + $signed({{(A - 2 * P){prod_s[2*P-1]}}, prod_s});
            end

            // Kernel row/column walk only during depthwise tap issue; parked at 0 otherwise
            if ((state_q == S_DW) && (s_q < SW'(KK - 1))) begin
               if (kx_q == KW'(K - 1)) begin
                  kx_d = '0;
                  ky_d = ky_q + KW'(1);
               end else begin
                  kx_d = kx_q + KW'(1);
                  ky_d = ky_q;
               end
            end else begin
               kx_d = '0;
               ky_d = '0;
            end

            if (s_q == n_last_s + SW'(1)) begin
               s_d = '0;
               if (ox_q == OW'(OS - 1)) begin
                  ox_d = '0;
                  if (oy_q == OW'(OS - 1)) begin
                     oy_d = '0;
                     if (ch_q == last_ch_s) begin
                        ch_d    = '0;
                        state_d = (state_q == S_DW) ? S_GAP : S_FIN;
                     end else begin
                        ch_d = ch_q + CW'(1);
                     end
                  end else begin
                     oy_d = oy_q + OW'(1);
                  end
               end else begin
                  ox_d = ox_q + OW'(1);
               end
            end else begin
               s_d = s_q + SW'(1);
            end
         end
         S_GAP: begin
            // Last intermediate write drains here before any pointwise read
            state_d = S_PW;
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read strobes/addresses for the cycle described by the next-state counters,
   // so they can be registered and still line up with that cycle
   always_comb begin
      busy_d    = (state_d != S_IDLE);
      rd_en_d   = 1'b0;
      rd_sel_d  = 1'b0;
      rd_addr_d = '0;
      wt_en_d   = 1'b0;
      wt_addr_d = '0;
      if (state_d == S_DW) begin
         if (s_d < SW'(KK)) begin
            rd_en_d   = 1'b1;
            wt_en_d   = 1'b1;
            rd_addr_d = RAW'(((32'(oy_d) + 32'(ky_d)) * 32'(IS) + 32'(ox_d) + 32'(kx_d))
                             * 32'(IC) + 32'(ch_d));
            wt_addr_d = WTW'(32'(ch_d) * 32'(KK) + 32'(ky_d) * 32'(K) + 32'(kx_d));
         end else if (s_d == SW'(KK)) begin
            wt_en_d   = 1'b1;
            wt_addr_d = WTW'(32'(WB_DB) + 32'(ch_d));
         end else begin
            wt_en_d   = 1'b0;
         end
      end else if (state_d == S_PW) begin
         rd_sel_d = 1'b1;
         if (s_d < SW'(IC)) begin
            rd_en_d   = 1'b1;
            wt_en_d   = 1'b1;
            rd_addr_d = RAW'((32'(s_d) * 32'(OS) + 32'(oy_d)) * 32'(OS) + 32'(ox_d));
            wt_addr_d = WTW'(32'(WB_PK) + 32'(ch_d) * 32'(IC) + 32'(s_d));
         end else if (s_d == SW'(IC)) begin
            wt_en_d   = 1'b1;
            wt_addr_d = WTW'(32'(WB_PB) + 32'(ch_d));
         end else begin
            wt_en_d   = 1'b0;
         end
      end else begin
         rd_sel_d = 1'b0;
      end
   end

   // State, counter, accumulator and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         oy_q      <= '0;
         ox_q      <= '0;
         s_q       <= '0;
         ky_q      <= '0;
         kx_q      <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_sel_q  <= 1'b0;
         rd_addr_q <= '0;
         wt_en_q   <= 1'b0;
         wt_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         oy_q      <= oy_d;
         ox_q      <= ox_d;
         s_q       <= s_d;
         ky_q      <= ky_d;
         kx_q      <= kx_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         rd_sel_q  <= rd_sel_d;
         rd_addr_q <= rd_addr_d;
         wt_en_q   <= wt_en_d;
         wt_addr_q <= wt_addr_d;
         wr_en_q   <= wr_en_d;
         wr_sel_q  <= wr_sel_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_en   = rd_en_q;
   assign bus.rd_sel  = rd_sel_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.wt_en   = wt_en_q;
   assign bus.wt_addr = wt_addr_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_sel  = wr_sel_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
endmodule
